// File: rtl/rv_cpu_pipe.sv
// rv_cpu_pipe: 5-stage RV32I-subset core (IF/ID/EX/MEM/WB) with combinational imem/dmem ports.
// Optional macro RV_CPU_FWD_EN enables EX-stage forwarding; without it RAW hazards stall in ID.
package rv_cpu_pkg;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wr_data;
        logic        wr_en;
        logic [3:0]  byte_en;
    } t_core2mem_req;
endpackage

module rv_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rs1_val_o,
    output logic [31:0] rs2_val_o,
    output logic [31:0] imm_o,
    output logic [2:0]  alu_f3_o,
    output logic        alu_alt_o,
    output logic        use_imm_o,
    output logic        zero_a_o,
    output logic        use_rs1_o,
    output logic        use_rs2_o,
    output logic        we_o,
    output logic        is_lw_o,
    output logic        is_sw_o
);
    logic [31:0] rf [0:31];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign rd_o  = instr_i[11:7];
    assign rs1_o = instr_i[19:15];
    assign rs2_o = instr_i[24:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we_i && wb_rd_i != 5'd0) begin
            rf[wb_rd_i] <= wb_data_i;
        end
    end

    // Write-through: a WB write lands in the same cycle it is read here
    assign rs1_val_o = (rs1_o == 5'd0) ? '0 : (wb_we_i && wb_rd_i == rs1_o) ? wb_data_i : rf[rs1_o];
    assign rs2_val_o = (rs2_o == 5'd0) ? '0 : (wb_we_i && wb_rd_i == rs2_o) ? wb_data_i : rf[rs2_o];

    always_comb begin
        we_o      = 1'b0;
        is_lw_o   = 1'b0;
        is_sw_o   = 1'b0;
        use_imm_o = 1'b0;
        zero_a_o  = 1'b0;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        alu_f3_o  = 3'b000;
        alu_alt_o = 1'b0;
        imm_o     = {{20{instr_i[31]}}, instr_i[31:20]};
        case (opc)
            7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
                we_o = 1'b1; use_rs1_o = 1'b1; use_rs2_o = 1'b1;
                alu_f3_o = f3; alu_alt_o = f7[5];
            end
            7'b0010011: if ((f3 != 3'b001 && f3 != 3'b101) || f7 == 7'h00 ||
                            (f3 == 3'b101 && f7 == 7'h20)) begin
                we_o = 1'b1; use_rs1_o = 1'b1; use_imm_o = 1'b1;
                alu_f3_o = f3; alu_alt_o = (f3 == 3'b101) && f7[5];
            end
            7'b0000011: if (f3 == 3'b010) begin
                we_o = 1'b1; is_lw_o = 1'b1; use_rs1_o = 1'b1; use_imm_o = 1'b1;
            end
            7'b0100011: if (f3 == 3'b010) begin
                is_sw_o = 1'b1; use_rs1_o = 1'b1; use_rs2_o = 1'b1; use_imm_o = 1'b1;
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            7'b0110111: begin
                we_o = 1'b1; use_imm_o = 1'b1; zero_a_o = 1'b1;
                imm_o = {instr_i[31:12], 12'h000};
            end
            default: ;
        endcase
    end
endmodule

module rv_cpu_pipe
    import rv_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rd_data,
    output t_core2mem_req core2dmem_req,
    input  logic [31:0]   dmem_rd_data
);
    typedef struct packed {
        logic vld, we, lw, sw, imm_sel, zero_a, alt;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b, imm;
    } t_idex;
    typedef struct packed {
        logic vld, we, lw, sw;
        logic [4:0]  rd;
        logic [31:0] res, sdata;
    } t_exmem;
    typedef struct packed {
        logic vld, we;
        logic [4:0]  rd;
        logic [31:0] data;
    } t_memwb;

    logic [31:0] pc_q, ifid_instr_q;
    logic        ifid_vld_q, stall;
    t_idex       idex_q, idex_d;
    t_exmem      exmem_q, exmem_d;
    t_memwb      memwb_q, memwb_d;

    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [31:0] d_a, d_b, d_imm, ex_a, ex_b, op_a, op_b, alu;
    logic [2:0]  d_f3;
    logic        d_alt, d_imm_sel, d_zero_a, d_u1, d_u2, d_we, d_lw, d_sw;

    rv_decode u_rv_decode (
        .clk(clk), .rst(rst), .instr_i(ifid_instr_q),
        .wb_we_i(memwb_q.vld && memwb_q.we), .wb_rd_i(memwb_q.rd), .wb_data_i(memwb_q.data),
        .rs1_o(d_rs1), .rs2_o(d_rs2), .rd_o(d_rd), .rs1_val_o(d_a), .rs2_val_o(d_b),
        .imm_o(d_imm), .alu_f3_o(d_f3), .alu_alt_o(d_alt), .use_imm_o(d_imm_sel),
        .zero_a_o(d_zero_a), .use_rs1_o(d_u1), .use_rs2_o(d_u2), .we_o(d_we),
        .is_lw_o(d_lw), .is_sw_o(d_sw)
    );

    function automatic logic reads(input logic vld, input logic we, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic u1, input logic u2);
        return vld && we && rd != 5'd0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    endfunction

`ifdef RV_CPU_FWD_EN
    assign stall = ifid_vld_q && idex_q.lw &&
                   reads(idex_q.vld, idex_q.we, idex_q.rd, d_rs1, d_rs2, d_u1, d_u2);
`else
    assign stall = ifid_vld_q &&
                   (reads(idex_q.vld, idex_q.we, idex_q.rd, d_rs1, d_rs2, d_u1, d_u2) ||
                    reads(exmem_q.vld, exmem_q.we, exmem_q.rd, d_rs1, d_rs2, d_u1, d_u2) ||
                    reads(memwb_q.vld, memwb_q.we, memwb_q.rd, d_rs1, d_rs2, d_u1, d_u2));
    logic unused_rs;
    assign unused_rs = ^{idex_q.rs1, idex_q.rs2};
`endif

    always_comb begin
        idex_d = '0;
        if (ifid_vld_q && !stall) begin
            idex_d = '{vld: 1'b1, we: d_we, lw: d_lw, sw: d_sw, imm_sel: d_imm_sel,
                       zero_a: d_zero_a, alt: d_alt, f3: d_f3, rd: d_rd, rs1: d_rs1,
                       rs2: d_rs2, a: d_a, b: d_b, imm: d_imm};
        end
    end

    // EX/MEM is checked last so it wins over MEM/WB
    always_comb begin
        ex_a = idex_q.a;
        ex_b = idex_q.b;
`ifdef RV_CPU_FWD_EN
        if (memwb_q.vld && memwb_q.we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) ex_a = memwb_q.data;
        if (memwb_q.vld && memwb_q.we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) ex_b = memwb_q.data;
        if (exmem_q.vld && exmem_q.we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1) ex_a = exmem_q.res;
        if (exmem_q.vld && exmem_q.we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2) ex_b = exmem_q.res;
`endif
    end

    assign op_a = idex_q.zero_a ? '0 : ex_a;
    assign op_b = idex_q.imm_sel ? idex_q.imm : ex_b;

    always_comb begin
        case (idex_q.f3)
            3'b000:  alu = idex_q.alt ? op_a - op_b : op_a + op_b;
            3'b001:  alu = op_a << op_b[4:0];
            3'b010:  alu = {31'b0, $signed(op_a) < $signed(op_b)};
            3'b011:  alu = {31'b0, op_a < op_b};
            3'b100:  alu = op_a ^ op_b;
            3'b101:  alu = idex_q.alt ? 32'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
            3'b110:  alu = op_a | op_b;
            default: alu = op_a & op_b;
        endcase
        exmem_d = '{vld: idex_q.vld, we: idex_q.we, lw: idex_q.lw, sw: idex_q.sw,
                    rd: idex_q.rd, res: alu, sdata: ex_b};
        memwb_d = '{vld: exmem_q.vld, we: exmem_q.we, rd: exmem_q.rd,
                    data: exmem_q.lw ? dmem_rd_data : exmem_q.res};
    end

    assign imem_addr             = pc_q;
    assign core2dmem_req.address = exmem_q.res;
    assign core2dmem_req.wr_data = exmem_q.sdata;
    assign core2dmem_req.wr_en   = exmem_q.vld && exmem_q.sw && !rst;
    assign core2dmem_req.byte_en = (exmem_q.vld && (exmem_q.lw || exmem_q.sw) && !rst) ? 4'hF : 4'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_vld_q   <= 1'b0;
            ifid_instr_q <= '0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
        end else begin
            if (!stall) begin
                pc_q         <= pc_q + 32'd4;
                ifid_vld_q   <= 1'b1;
                ifid_instr_q <= imem_rd_data;
            end
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end
endmodule

// File: tb/tb_rv_cpu_pipe.sv
// Self-checking bench for rv_cpu_pipe: directed programs plus random programs vs an ISA-level model.
module tb_rv_cpu_pipe;
    import rv_cpu_pkg::*;

    typedef enum int {
        I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA, I_SLT, I_SLTU,
        I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLTI, I_SLTIU, I_SLLI, I_SRLI, I_SRAI,
        I_LUI, I_LW, I_SW, I_BR
    } op_e;
    typedef struct {
        op_e         op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } ins_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_clr = 1'b0;
    logic [31:0]   imem_addr, imem_rd_data, dmem_rd_data;
    t_core2mem_req req;
    logic [31:0]   rom   [0:255];
    logic [31:0]   dmem  [0:255];
    logic [31:0]   m_rf  [0:31];
    logic [31:0]   m_mem [0:255];
    ins_t          prog [$];
    int            total = 0, bad = 0, wr_cnt = 0, stall_cnt = 0;

    always #5 clk = ~clk;

    rv_cpu_pipe #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
        .core2dmem_req(req), .dmem_rd_data(dmem_rd_data)
    );

    assign imem_rd_data = (imem_addr[31:10] == 22'd0) ? rom[imem_addr[9:2]] : 32'h0;
    assign dmem_rd_data = dmem[req.address[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) dmem[i[7:0]] <= 32'h0;
        end else if (req.wr_en) begin
            for (int b = 0; b < 4; b++)
                if (req.byte_en[b]) dmem[req.address[9:2]][8*b +: 8] <= req.wr_data[8*b +: 8];
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic ins_t mk(op_e op, int rd, int rs1, int rs2, logic [31:0] imm);
        ins_t x;
        x.op = op; x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.imm = imm;
        return x;
    endfunction

    function automatic logic [31:0] enc(ins_t x);
        logic [4:0]  d, s1, s2;
        logic [31:0] im;
        d = x.rd; s1 = x.rs1; s2 = x.rs2; im = x.imm;
        case (x.op)
            I_ADD:   return {7'h00, s2, s1, 3'd0, d, 7'h33};
            I_SUB:   return {7'h20, s2, s1, 3'd0, d, 7'h33};
            I_SLL:   return {7'h00, s2, s1, 3'd1, d, 7'h33};
            I_SLT:   return {7'h00, s2, s1, 3'd2, d, 7'h33};
            I_SLTU:  return {7'h00, s2, s1, 3'd3, d, 7'h33};
            I_XOR:   return {7'h00, s2, s1, 3'd4, d, 7'h33};
            I_SRL:   return {7'h00, s2, s1, 3'd5, d, 7'h33};
            I_SRA:   return {7'h20, s2, s1, 3'd5, d, 7'h33};
            I_OR:    return {7'h00, s2, s1, 3'd6, d, 7'h33};
            I_AND:   return {7'h00, s2, s1, 3'd7, d, 7'h33};
            I_ADDI:  return {im[11:0], s1, 3'd0, d, 7'h13};
            I_SLTI:  return {im[11:0], s1, 3'd2, d, 7'h13};
            I_SLTIU: return {im[11:0], s1, 3'd3, d, 7'h13};
            I_XORI:  return {im[11:0], s1, 3'd4, d, 7'h13};
            I_ORI:   return {im[11:0], s1, 3'd6, d, 7'h13};
            I_ANDI:  return {im[11:0], s1, 3'd7, d, 7'h13};
            I_SLLI:  return {7'h00, im[4:0], s1, 3'd1, d, 7'h13};
            I_SRLI:  return {7'h00, im[4:0], s1, 3'd5, d, 7'h13};
            I_SRAI:  return {7'h20, im[4:0], s1, 3'd5, d, 7'h13};
            I_LUI:   return {im[31:12], d, 7'h37};
            I_LW:    return {im[11:0], s1, 3'd2, d, 7'h03};
            I_SW:    return {im[11:5], s2, s1, 3'd2, im[4:0], 7'h23};
            default: return {im[11:5], s2, s1, 3'd0, im[4:0], 7'h63};
        endcase
    endfunction

    // Architectural reference: one instruction at a time, no pipeline notion
    task automatic model_exec(input ins_t x);
        logic [31:0] a, b, r, ad;
        logic        w;
        a = m_rf[x.rs1]; b = m_rf[x.rs2]; ad = a + x.imm; w = 1'b1; r = 32'h0;
        case (x.op)
            I_ADD:   r = a + b;
            I_SUB:   r = a - b;
            I_AND:   r = a & b;
            I_OR:    r = a | b;
            I_XOR:   r = a ^ b;
            I_SLL:   r = a << b[4:0];
            I_SRL:   r = a >> b[4:0];
            I_SRA:   r = 32'($signed(a) >>> b[4:0]);
            I_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            I_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            I_ADDI:  r = a + x.imm;
            I_ANDI:  r = a & x.imm;
            I_ORI:   r = a | x.imm;
            I_XORI:  r = a ^ x.imm;
            I_SLTI:  r = ($signed(a) < $signed(x.imm)) ? 32'd1 : 32'd0;
            I_SLTIU: r = (a < x.imm) ? 32'd1 : 32'd0;
            I_SLLI:  r = a << x.imm[4:0];
            I_SRLI:  r = a >> x.imm[4:0];
            I_SRAI:  r = 32'($signed(a) >>> x.imm[4:0]);
            I_LUI:   r = x.imm;
            I_LW:    r = m_mem[ad[9:2]];
            I_SW:    begin w = 1'b0; m_mem[ad[9:2]] = b; end
            default: w = 1'b0;
        endcase
        if (w && x.rd != 5'd0) m_rf[x.rd] = r;
    endtask

    task automatic load_run(input int cycles, input logic clr);
        logic [31:0] prev;
        for (int i = 0; i < 256; i++) rom[i[7:0]] = 32'h0;
        for (int i = 0; i < prog.size(); i++) rom[i[7:0]] = enc(prog[i]);
        for (int i = 0; i < 32; i++) m_rf[i[4:0]] = 32'h0;
        if (clr) for (int i = 0; i < 256; i++) m_mem[i[7:0]] = 32'h0;
        foreach (prog[i]) model_exec(prog[i]);
        rst = 1'b1; mem_clr = clr;
        repeat (2) @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        stall_cnt = 0; prev = imem_addr;
        repeat (cycles) begin
            @(negedge clk);
            if (imem_addr == prev) stall_cnt++;
            prev = imem_addr;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i[7:0]] = 32'h0;
        rst = 1'b1; mem_clr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", imem_addr); end
            total++; if (req.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", req.wr_en); end
            total++; if (req.byte_en !== 4'h0) begin bad++; $display("FAIL reset_byte_en got=%h exp=0", req.byte_en); end
        end
        for (int i = 1; i < 32; i++) begin
            total++;
            if (dut.u_rv_decode.rf[i[4:0]] !== 32'h0) begin
                bad++; $display("FAIL reset_rf x%0d got=%h exp=0", i, dut.u_rv_decode.rf[i[4:0]]);
            end
        end
        rst = 1'b0; mem_clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (imem_addr !== 32'(4 * k)) begin bad++; $display("FAIL pc_seq got=%h exp=%h", imem_addr, 32'(4 * k)); end
            if (k == 0) begin
                total++; if (req.wr_en !== 1'b0) begin bad++; $display("FAIL post_reset_wr_en got=%b exp=0", req.wr_en); end
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_rf(input string nm, input int r, input logic [31:0] exp);
        total++;
        if (dut.u_rv_decode.rf[5'(r)] !== exp) begin
            bad++; $display("FAIL %s x%0d got=%h exp=%h", nm, r, dut.u_rv_decode.rf[5'(r)], exp);
        end
    endtask

    task automatic test_raw();
        prog.delete();
        prog.push_back(mk(I_ADDI, 1, 0, 0, 32'd10));
        prog.push_back(mk(I_ADDI, 2, 0, 0, 32'd20));
        prog.push_back(mk(I_ADD,  3, 1, 2, 32'd0));
        prog.push_back(mk(I_SUB,  4, 2, 1, 32'd0));
        load_run(30, 1'b1);
        chk_rf("raw", 1, 32'd10); chk_rf("raw", 2, 32'd20);
        chk_rf("raw", 3, 32'd30); chk_rf("raw", 4, 32'd10);
    endtask

    task automatic test_load_use();
        prog.push_back(mk(I_SW,   0, 0, 3, 32'd0));
        prog.push_back(mk(I_LW,   5, 0, 0, 32'd0));
        prog.push_back(mk(I_ADDI, 6, 5, 0, 32'd5));
        load_run(40, 1'b1);
        total++; if (dmem[0] !== 32'd30) begin bad++; $display("FAIL ld_use_mem0 got=%h exp=%h", dmem[0], 32'd30); end
        chk_rf("ld_use", 5, 32'd30); chk_rf("ld_use", 6, 32'd35);
`ifdef RV_CPU_FWD_EN
        total++; if (stall_cnt != 1) begin bad++; $display("FAIL ld_use_stalls got=%0d exp=1", stall_cnt); end
`endif
    endtask

    task automatic test_x0();
        prog.delete();
        prog.push_back(mk(I_ADDI, 7, 0, 0, 32'd3));
        prog.push_back(mk(I_ADDI, 0, 0, 0, 32'd7));
        prog.push_back(mk(I_ADD,  7, 0, 0, 32'd0));
        load_run(30, 1'b0);
        chk_rf("x0", 0, 32'h0); chk_rf("x0", 7, 32'h0);
    endtask

    task automatic test_wrap_sign();
        prog.delete();
        prog.push_back(mk(I_ADDI, 8,  0, 0, 32'hFFFF_FFFF));
        prog.push_back(mk(I_ADD,  9,  8, 8, 32'd0));
        prog.push_back(mk(I_SRAI, 10, 8, 0, 32'd4));
        prog.push_back(mk(I_SLTU, 11, 0, 8, 32'd0));
        load_run(30, 1'b0);
        chk_rf("wrap", 9, 32'hFFFF_FFFE); chk_rf("wrap", 10, 32'hFFFF_FFFF); chk_rf("wrap", 11, 32'd1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            prog.delete();
            for (int n = 0; n < 30; n++) begin
                ins_t        x;
                logic [11:0] r12;
                logic [31:0] t;
                r12 = 12'($urandom); t = $urandom;
                x = mk(op_e'($urandom_range(0, 22)), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), {{20{r12[11]}}, r12});
                if (x.op inside {I_SLLI, I_SRLI, I_SRAI}) x.imm = 32'($urandom_range(0, 31));
                if (x.op == I_LUI) x.imm = {t[31:12], 12'h000};
                if (x.op inside {I_LW, I_SW}) begin x.rs1 = 5'd0; x.imm = 32'(4 * $urandom_range(0, 15)); end
                prog.push_back(x);
            end
            load_run(140, 1'b1);
            for (int r = 0; r < 32; r++) chk_rf("rand", r, m_rf[r[4:0]]);
            for (int w = 0; w < 16; w++) begin
                total++;
                if (dmem[w[7:0]] !== m_mem[w[7:0]]) begin
                    bad++; $display("FAIL rand_mem[%0d] got=%h exp=%h", w, dmem[w[7:0]], m_mem[w[7:0]]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int wc0, n;
        prog.delete();
        prog.push_back(mk(I_ADDI, 1, 0, 0, 32'd5));
        prog.push_back(mk(I_ADDI, 2, 0, 0, 32'd9));
        for (int i = 0; i < 4; i++) prog.push_back(mk(I_BR, 0, 0, 0, 32'd0));
        prog.push_back(mk(I_SW, 0, 0, 1, 32'd4));
        load_run(0, 1'b1);
        n = 0;
        while (imem_addr !== 32'd24 && n < 50) begin @(negedge clk); n++; end
        total++; if (n >= 50) begin bad++; $display("FAIL rst_mid_wait got=%h exp=%h", imem_addr, 32'd24); end
        repeat (2) @(negedge clk);
        chk_rf("rst_mid_pre", 1, 32'd5);
        wc0 = wr_cnt;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++; if (req.wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_en got=%b exp=0", req.wr_en); end
        end
        total++; if (wr_cnt != wc0) begin bad++; $display("FAIL rst_mid_writes got=%0d exp=%0d", wr_cnt, wc0); end
        total++; if (dmem[1] !== 32'h0) begin bad++; $display("FAIL rst_mid_mem1 got=%h exp=0", dmem[1]); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_mid_pc got=%h exp=0", imem_addr); end
        for (int r = 1; r < 32; r++) chk_rf("rst_mid_rf", r, 32'h0);
        for (int i = 0; i < 256; i++) rom[i[7:0]] = 32'h0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_raw();
        test_load_use();
        test_x0();
        test_wrap_sign();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
